// File: rtl/ofifo_deskew.sv
// Output de-skew FIFO: one circular buffer per array column,
// popped as a re-aligned whole row once every column holds data.
module ofifo_deskew #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*bw-1:0]        in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [col*bw-1:0]        out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic [$clog2(depth):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULLV = (AW+1)'(depth);

  logic [AW:0]       w_occ [col];
  logic [col-1:0]    w_full;
  logic [col-1:0]    w_empty;
  logic [col*bw-1:0] w_head;
  logic [AW:0]       w_min;
  logic              w_acc;

  assign w_acc = rd & o_valid;

  genvar g;
  for (g = 0; g < col; g++) begin : g_col
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [bw-1:0] r_mem [depth];
    logic          w_we;

    assign w_occ[g]   = r_wptr - r_rptr;
    assign w_full[g]  = (w_occ[g] == FULLV);
    assign w_empty[g] = (w_occ[g] == '0);
    assign w_we       = wr[g] & ~w_full[g];
    assign w_head[g*bw +: bw] = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_we)  r_wptr <= r_wptr + 1'b1;
        if (w_acc) r_rptr <= r_rptr + 1'b1;
      end
    end

    // Storage needs no reset; pointers define what is live.
    always_ff @(posedge clk) begin
      if (!reset && w_we)
        r_mem[r_wptr[AW-1:0]] <= in[g*bw +: bw];
    end
  end

  always_comb begin
    w_min = w_occ[0];
    for (int i = 1; i < col; i++)
      if (w_occ[i] < w_min) w_min = w_occ[i];
  end

  assign o_valid = ~|w_empty;
  assign o_full  = |w_full;
  assign o_ready = ~o_full;
  assign o_count = w_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (w_acc)           out         <= w_head;
      if (|(wr & w_full))  o_overflow  <= 1'b1;
      if (rd && !o_valid)  o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo_deskew.sv
// Directed bench for ofifo_deskew: skew, fill/overflow,
// underflow, wrap streaming, same-cycle r/w, mid-stream reset.
module tb_ofifo_deskew;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [COL*BW-1:0] din;
  logic [COL-1:0]   wr;
  logic             rd;
  logic [COL*BW-1:0] dout;
  logic             o_valid, o_full, o_ready;
  logic [6:0]       o_count;
  logic             o_overflow, o_underflow;

  int nvec = 0;
  int nerr = 0;

  ofifo_deskew #(.col(COL), .bw(BW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd),
    .out(dout), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rowv(input int r);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < COL; i++)
      v[i*BW +: BW] = 16'(r * 8 + i);
    return v;
  endfunction

  function automatic logic [127:0] rowf(input int r);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < COL; i++)
      v[i*BW +: BW] = 16'((i << 8) | r);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [127:0] exp;
    int nr;
    reset = 1'b0; din = '0; wr = '0; rd = 1'b0;

    // reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_full",  128'(o_full),  128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_out",   dout,          128'(0));
    chk("rst_flags", 128'({o_overflow, o_underflow}), 128'(0));

    // underflow on empty buffers
    rd = 1'b1; tick(); rd = 1'b0;
    chk("uf_flag",  128'(o_underflow), 128'(1));
    chk("uf_out",   dout,              128'(0));
    chk("uf_count", 128'(o_count),     128'(0));

    // skewed single row, then a valid read after underflow
    exp = '0;
    for (int i = 0; i < COL; i++) begin
      wr = 8'(1) << i;
      din = '0;
      din[i*BW +: BW] = 16'(16'h0100 + i);
      exp[i*BW +: BW] = 16'(16'h0100 + i);
      tick();
      chk("skew_valid", 128'(o_valid), 128'(i == COL-1));
    end
    wr = '0;
    chk("skew_count", 128'(o_count), 128'(1));
    rd = 1'b1; tick(); rd = 1'b0;
    chk("skew_out",   dout,          exp);
    chk("skew_vlow",  128'(o_valid), 128'(0));

    // fill 64 skewed rows, then overflow column 0
    do_reset();
    for (int t = 0; t < DEP + COL - 1; t++) begin
      wr = '0; din = '0;
      for (int i = 0; i < COL; i++)
        if (t - i >= 0 && t - i < DEP) begin
          wr[i] = 1'b1;
          din[i*BW +: BW] = 16'(((i << 8) | (t - i)));
        end
      tick();
      if (t == DEP - 1) begin
        chk("fill_full",  128'(o_full),  128'(1));
        chk("fill_ready", 128'(o_ready), 128'(0));
        chk("fill_cnt57", 128'(o_count), 128'(DEP - COL + 1));
      end
    end
    chk("fill_cnt", 128'(o_count), 128'(DEP));
    chk("fill_ovf0", 128'(o_overflow), 128'(0));
    wr = 8'h01; din = '0; din[15:0] = 16'hdead;
    tick();
    wr = '0;
    chk("ovf_flag", 128'(o_overflow), 128'(1));
    chk("ovf_cnt",  128'(o_count),    128'(DEP));
    for (int r = 0; r < DEP; r++) begin
      rd = 1'b1; tick();
      chk("fill_rd", dout, rowf(r));
    end
    rd = 1'b0;
    chk("drain_valid", 128'(o_valid), 128'(0));
    chk("drain_ready", 128'(o_ready), 128'(1));

    // wrap-around streaming, 200 skewed rows
    do_reset();
    nr = 0;
    for (int t = 0; t < 200 + COL - 1 + 20; t++) begin
      wr = '0; din = '0;
      for (int i = 0; i < COL; i++)
        if (t - i >= 0 && t - i < 200) begin
          wr[i] = 1'b1;
          din[i*BW +: BW] = 16'((t - i) * 8 + i);
        end
      rd = o_valid;
      tick();
      if (rd) begin
        chk("stream_row", dout, rowv(nr));
        nr++;
      end
      chk("stream_cnt_le8", 128'(o_count <= 7'd8), 128'(1));
    end
    rd = 1'b0; wr = '0;
    chk("stream_rows", 128'(nr), 128'(200));
    chk("stream_flags", 128'({o_overflow, o_underflow, o_full}), 128'(0));

    // same-cycle read and write at occupancy 1
    do_reset();
    wr = '1; din = rowv(300); tick();
    chk("rw_cnt0", 128'(o_count), 128'(1));
    rd = 1'b1; din = rowv(301); tick();
    wr = '0;
    chk("rw_out_old", dout, rowv(300));
    chk("rw_cnt1",    128'(o_count), 128'(1));
    tick();
    rd = 1'b0;
    chk("rw_out_new", dout, rowv(301));
    chk("rw_cnt2",    128'(o_count), 128'(0));

    // reset mid-operation
    do_reset();
    for (int r = 0; r < 10; r++) begin
      wr = '1; din = rowv(400 + r); tick();
    end
    wr = 8'h0f; din = rowv(500); tick();
    wr = '0;
    chk("mid_cnt10", 128'(o_count), 128'(10));
    rd = 1'b1; tick(); rd = 1'b0;
    chk("mid_rd", dout, rowv(400));
    rd = 1'b1; reset = 1'b1; wr = '1; tick();
    rd = 1'b0; reset = 1'b0; wr = '0;
    chk("mid_valid", 128'(o_valid), 128'(0));
    chk("mid_count", 128'(o_count), 128'(0));
    chk("mid_out",   dout,          128'(0));
    chk("mid_flags", 128'({o_overflow, o_underflow}), 128'(0));
    wr = '1; din = rowv(600); tick();
    wr = '1; din = rowv(601); tick();
    wr = '0;
    chk("post_cnt", 128'(o_count), 128'(2));
    rd = 1'b1; tick();
    chk("post_rd0", dout, rowv(600));
    tick(); rd = 1'b0;
    chk("post_rd1", dout, rowv(601));
    chk("post_valid", 128'(o_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ofifo_deskew.md
Name: ofifo_deskew

Overview:
- Output-side buffer between the systolic array's bottom-row partial-sum outputs and the downstream reader (SRAM writeback / SFU).
- Array columns emit results with a diagonal skew: column i is valid one cycle after column i-1.
- Each column writes into its own circular buffer under its own strobe.
- The block presents a re-aligned, whole-row read interface. A row is poppable only when every column holds at least one entry.

Parameters:
- col, 8, number of array columns (>=2).
- bw, 16, bits per column entry (psum width).
- depth, 64, entries per column buffer; power of 2, >=4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in  input  col*bw  column data; column i occupies bits [(i+1)*bw-1 : i*bw].
- wr  input  col  per-column write strobe; bit i writes in slice i into column buffer i.
- rd  input  1  pop one aligned row from all columns.
- out  output  col*bw  registered row data; same slicing as in.
- o_valid  output  1  at least one complete row is available.
- o_full  output  1  any column buffer is full.
- o_ready  output  1  equals ~o_full.
- o_count  output  log2(depth)+1  number of complete rows, equal to the minimum occupancy over all columns.
- o_overflow  output  1  sticky: a write was dropped.
- o_underflow  output  1  sticky: rd was asserted while o_valid was low.

Behaviour:

Reset:
- All pointers, occupancies, out, o_overflow and o_underflow clear to 0.
- After reset: o_valid=0, o_full=0, o_ready=1, o_count=0.
- Storage contents are don't-care.
- Reset has priority over rd/wr in the same cycle.
- Reset mid-stream discards all buffered data. No partial row survives.

Per-column storage:
- Each column keeps a wr_ptr and rd_ptr of log2(depth)+1 bits; the MSB is the wrap bit.
- occ_i = wr_ptr_i - rd_ptr_i, modulo 2^(log2(depth)+1).
- empty_i = (occ_i == 0).
- full_i = (occ_i == depth), i.e. indices equal and wrap bits differ.
- Pointers wrap naturally at 2*depth. Index = low log2(depth) bits.

Write:
- Evaluated independently per column.
- If wr[i]=1 and full_i=0 (pre-edge state): store the in slice at the wr_ptr_i index, then wr_ptr_i += 1.
- If wr[i]=1 and full_i=1: drop the write, no pointer change, and set o_overflow.
- This holds even when rd pops in the same cycle. The full check always uses pre-edge state.

Read:
- Row accepted iff rd=1 and o_valid=1 (pre-edge).
- On accept: every rd_ptr_i += 1, and out is loaded with the head entry of every column.
- Read latency: out shows the row on the cycle after the accepting edge.
- out holds its value when no read is accepted.
- rd=1 with o_valid=0: no state change except setting o_underflow; out holds.

Simultaneous read and write:
- rd accepted and wr[i] on the same edge: both take effect, occ_i is unchanged.
- Reading from a column with occ_i=1 while writing it is legal. out receives the old head; the new entry becomes the head.

Flags and outputs:
- o_valid = AND over i of ~empty_i.
- o_count = min over i of occ_i. Combinational from registered state; no extra latency.
- o_full, o_ready, o_valid and o_count reflect post-edge state one cycle after the causing write or read.
- o_overflow and o_underflow clear only on reset.

Usage:
- Normal operation has the producer stop when o_ready=0.
- Due to the skew, column col-1 can lag by up to col-1 entries. Producers must therefore watch o_ready, not o_valid.

Test Plan:
- Skewed write: reset, then drive wr[i] at cycle 2+i with value 16'h0100+i in slice i, one row -> o_valid stays 0 through cycle 2+col-1. Once column col-1 is written, o_valid=1 and o_count=1. Pulse rd: the next cycle out slice i = 16'h0100+i for all i, and o_valid=0.
- Fill/overflow: write depth=64 skewed rows without reads -> o_full=1 and o_ready=0 as soon as column 0 reaches 64. A 65th write to column 0 is dropped and o_overflow=1. Reading 64 rows returns values 0..63 in order per column, with no corruption.
- Underflow: assert rd with buffers empty after reset -> o_underflow=1, out stays 0, pointers unchanged. A subsequent valid row reads back correctly.
- Wrap-around streaming: 200 skewed rows with column-i data = row*8+i, reading whenever o_valid=1 -> all 200 rows read back aligned and in order. o_count never exceeds 8, and no flags are set.
- Simultaneous read/write at occ=1: with one complete row buffered, assert rd and wr[all] in the same cycle with new data -> out = old row, o_count stays 1, and the next read returns the new row.
- Reset mid-operation: 10 rows buffered plus a partial row in columns 0..3, then assert reset for one cycle -> o_valid=0, o_count=0, out=0, flags=0. New rows written after reset read back correctly, with no stale data.
